// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if: pixel bus between the VGA timing block and its neighbours.
// master: timing side (drives counters, syncs, colour); slave: pixel logic / sink side.
interface vga_timing_pipe_if;
  logic [2:0]  data;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        red_out;
  logic        green_out;
  logic        blue_out;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  data,
    output hcount,
    output vcount,
    output red_out,
    output green_out,
    output blue_out,
    output hsync,
    output vsync,
    output frame_start,
    output frame_count
  );

  modport slave (
    output data,
    input  hcount,
    input  vcount,
    input  red_out,
    input  green_out,
    input  blue_out,
    input  hsync,
    input  vsync,
    input  frame_start,
    input  frame_count
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA h/v counters, delayed sync/active/frame_start, gated colour.
// Ports: vga_clk (pixel clock), reset (async, active-low), bus (vga_timing_pipe_if.master).
module vga_timing_pipe #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_pipe_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } tap_t;

  localparam tap_t TAP_IDLE = '{
    hs:  1'b1,
    vs:  1'b1,
    act: 1'b0,
    fs:  1'b0
  };

  logic [9:0]  h_q;
  logic [9:0]  v_q;
  tap_t        raw;
  tap_t        pipe_q [PIPE_DELAY];
  tap_t        tail_in;
  tap_t        tail;
  logic [2:0]  col_q;
  logic [15:0] frame_count_q;
  logic        seen_q;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      if (v_q == V_LAST) begin
        v_q <= '0;
      end else begin
        v_q <= v_q + 10'd1;
      end
    end else begin
      h_q <= h_q + 10'd1;
    end
  end

  always_comb begin
    raw     = TAP_IDLE;
    raw.hs  = ~((h_q >= HS_BEG) && (h_q <= HS_END));
    raw.vs  = ~((v_q >= VS_BEG) && (v_q <= VS_END));
    raw.act = (h_q < H_VIS) && (v_q < V_VIS);
    raw.fs  = (h_q == 10'd0) && (v_q == 10'd0);
  end

  // Every stage resets to idle so no partial pulse leaks out.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= TAP_IDLE;
      end
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Value entering the last stage; the frame counter
  // updates on the same edge the delayed pulse appears.
  if (PIPE_DELAY == 1) begin : g_tail_one
    assign tail_in = raw;
  end else begin : g_tail_many
    assign tail_in = pipe_q[PIPE_DELAY-2];
  end

  assign tail = pipe_q[PIPE_DELAY-1];

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
    end else begin
      col_q <= bus.data;
    end
  end

  // First frame after reset is not counted.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
      seen_q        <= 1'b0;
    end else if (tail_in.fs) begin
      seen_q <= 1'b1;
      if (seen_q) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign bus.hcount      = h_q;
  assign bus.vcount      = v_q;
  assign bus.hsync       = tail.hs;
  assign bus.vsync       = tail.vs;
  assign bus.frame_start = tail.fs;
  assign bus.frame_count = frame_count_q;
  assign bus.red_out     = col_q[0] & tail.act;
  assign bus.green_out   = col_q[1] & tail.act;
  assign bus.blue_out    = col_q[2] & tail.act;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: random-stimulus bench for vga_timing_pipe
// on a reduced geometry, checked against an arithmetic timing model.
module tb_vga_timing_pipe;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int VA = 10;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;

  vga_timing_pipe_if bus ();

  vga_timing_pipe #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .PIPE_DELAY (PD)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #20 vga_clk = ~vga_clk;

  int         t;
  logic [2:0] d_last;
  int         vectors;
  int         errors;

  // t = rising edges since reset release; counters at t are (t%HT, t/HT%VT).
  function automatic int hx(input int tt);
    return tt % HT;
  endfunction

  function automatic int vx(input int tt);
    return (tt / HT) % VT;
  endfunction

  function automatic logic hs_x(input int tt);
    int h;
    if (tt < PD) return 1'b1;
    h = hx(tt - PD);
    return !(h >= HA + HF && h < HA + HF + HS);
  endfunction

  function automatic logic vs_x(input int tt);
    int v;
    if (tt < PD) return 1'b1;
    v = vx(tt - PD);
    return !(v >= VA + VF && v < VA + VF + VS);
  endfunction

  function automatic logic act_x(input int tt);
    if (tt < PD) return 1'b0;
    return hx(tt - PD) < HA && vx(tt - PD) < VA;
  endfunction

  function automatic logic fs_x(input int tt);
    if (tt < PD) return 1'b0;
    return (tt - PD) % FT == 0;
  endfunction

  function automatic logic [15:0] fc_x(input int tt);
    if (tt < PD) return 16'd0;
    return 16'((tt - PD) / FT);
  endfunction

  task automatic step(input logic [2:0] d);
    bus.data = d;
    @(posedge vga_clk);
    t++;
    d_last = d;
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.data = 3'b111;
    repeat (3) @(negedge vga_clk);
    vectors++;
    if (bus.hcount !== 10'd0 || bus.vcount !== 10'd0) begin
      errors++;
      $display("FAIL reset_cnt got h=%0d v=%0d exp 0 0", bus.hcount, bus.vcount);
    end
    vectors++;
    if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync got hs=%b vs=%b exp 1 1", bus.hsync, bus.vsync);
    end
    vectors++;
    if ({bus.blue_out, bus.green_out, bus.red_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_col got %b exp 000",
               {bus.blue_out, bus.green_out, bus.red_out});
    end
    vectors++;
    if (bus.frame_start !== 1'b0 || bus.frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame got fs=%b fc=%0d exp 0 0",
               bus.frame_start, bus.frame_count);
    end
    reset = 1'b1;
    t     = 0;
  endtask

  task automatic test_frames();
    int hs_low = 0;
    int vs_low = 0;
    int pulses = 0;
    for (int n = 0; n < 2 * FT + PD - 1; n++) begin
      step(3'($urandom));
      vectors++;
      if (bus.hcount !== 10'(hx(t)) || bus.vcount !== 10'(vx(t))) begin
        errors++;
        $display("FAIL frames_cnt t=%0d got h=%0d v=%0d exp %0d %0d",
                 t, bus.hcount, bus.vcount, hx(t), vx(t));
      end
      vectors++;
      if (bus.hsync !== hs_x(t) || bus.vsync !== vs_x(t)) begin
        errors++;
        $display("FAIL frames_sync t=%0d got hs=%b vs=%b exp %b %b",
                 t, bus.hsync, bus.vsync, hs_x(t), vs_x(t));
      end
      vectors++;
      if (bus.frame_start !== fs_x(t) || bus.frame_count !== fc_x(t)) begin
        errors++;
        $display("FAIL frames_fs t=%0d got fs=%b fc=%0d exp %b %0d",
                 t, bus.frame_start, bus.frame_count, fs_x(t), fc_x(t));
      end
      if (t >= PD) begin
        if (bus.hsync === 1'b0) hs_low++;
        if (bus.vsync === 1'b0) vs_low++;
      end
      if (bus.frame_start === 1'b1) begin
        vectors++;
        if (bus.frame_count !== 16'(pulses)) begin
          errors++;
          $display("FAIL frames_pulse_count got %0d exp %0d",
                   bus.frame_count, pulses);
        end
        pulses++;
      end
    end
    vectors++;
    if (hs_low != 2 * HS * VT || vs_low != 2 * VS * HT || pulses != 2) begin
      errors++;
      $display("FAIL frames_totals got hs=%0d vs=%0d p=%0d exp %0d %0d 2",
               hs_low, vs_low, pulses, 2 * HS * VT, 2 * VS * HT);
    end
  endtask

  task automatic test_colour_random();
    logic [2:0] got;
    logic [2:0] exp;
    for (int n = 0; n < FT; n++) begin
      step(3'($urandom));
      got = {bus.blue_out, bus.green_out, bus.red_out};
      exp = act_x(t) ? d_last : 3'b000;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL colour_rand t=%0d got %b exp %b", t, got, exp);
      end
    end
  endtask

  task automatic test_all_ones();
    int   lit = 0;
    logic [2:0] got;
    for (int n = 0; n < FT; n++) begin
      step(3'b111);
      got = {bus.blue_out, bus.green_out, bus.red_out};
      if (got === 3'b111) lit++;
      if (bus.hsync === 1'b0 || bus.vsync === 1'b0) begin
        vectors++;
        if (got !== 3'b000) begin
          errors++;
          $display("FAIL ones_blank t=%0d got %b exp 000", t, got);
        end
      end
    end
    vectors++;
    if (lit != HA * VA) begin
      errors++;
      $display("FAIL ones_total got %0d exp %0d", lit, HA * VA);
    end
  endtask

  task automatic test_upstream_reg();
    logic [9:0] hp;
    logic [9:0] cur;
    logic [2:0] got;
    logic [2:0] exp;
    logic [9:0] h2;
    hp = bus.hcount;
    step(3'b000);
    for (int n = 0; n < FT; n++) begin
      cur = bus.hcount;
      step(hp[2:0]);
      hp  = cur;
      h2  = 10'(hx(t - 2));
      got = {bus.blue_out, bus.green_out, bus.red_out};
      exp = act_x(t) ? h2[2:0] : 3'b000;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL upstream t=%0d got %b exp %b", t, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (hx(t) != HA + HF + 2 && guard < HT + 2) begin
      step(3'($urandom));
      guard++;
    end
    vectors++;
    if (bus.hcount !== 10'(HA + HF + 2) || bus.hsync !== hs_x(t)) begin
      errors++;
      $display("FAIL async_pre got h=%0d hs=%b exp %0d %b",
               bus.hcount, bus.hsync, HA + HF + 2, hs_x(t));
    end
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (bus.hcount !== 10'd0 || bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
      errors++;
      $display("FAIL async_now got h=%0d hs=%b vs=%b exp 0 1 1",
               bus.hcount, bus.hsync, bus.vsync);
    end
    vectors++;
    if (bus.frame_count !== 16'd0 || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_frame got fc=%0d fs=%b exp 0 0",
               bus.frame_count, bus.frame_start);
    end
    @(negedge vga_clk);
    reset = 1'b1;
    t     = 0;
    for (int n = 0; n < 2 * HT; n++) begin
      step(3'($urandom));
      vectors++;
      if (bus.hcount !== 10'(hx(t)) || bus.frame_start !== fs_x(t)
          || bus.frame_count !== fc_x(t)) begin
        errors++;
        $display("FAIL async_after t=%0d got h=%0d fs=%b fc=%0d exp %0d %b %0d",
                 t, bus.hcount, bus.frame_start, bus.frame_count,
                 hx(t), fs_x(t), fc_x(t));
      end
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (!fs_x(t + 1) && guard < FT + 2) begin
      step(3'($urandom));
      guard++;
    end
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    step(3'($urandom));
    vectors++;
    if (bus.frame_start !== 1'b1 || bus.frame_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got fs=%b fc=%h exp 1 0000",
               bus.frame_start, bus.frame_count);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout t=%0d", t);
    $fatal(1);
  end

  initial begin
    vectors  = 0;
    errors   = 0;
    t        = 0;
    d_last   = 3'b000;
    bus.data = 3'b000;
    test_reset();
    test_frames();
    test_colour_random();
    test_all_ones();
    test_upstream_reg();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter PIPE_DELAY, default 2, cycles from the counter outputs to the sync and colour outputs; legal range 1..4.
REQ-010 vga_clk  input  1  pixel clock (25 MHz); the only clock; all state changes on its rising edge.
REQ-011 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately; release is taken on the next vga_clk edge.
REQ-012 data  input  3  pixel colour {b,g,r}, produced by the upstream pixel logic from hcount/vcount.
REQ-013 hcount  output  10  current horizontal position, 0..H_total-1.
REQ-014 vcount  output  10  current line, 0..V_total-1.
REQ-015 red_out, green_out, blue_out  output  1 each  registered colour, forced to 0 outside the active area.
REQ-016 hsync, vsync  output  1 each  active-low sync pulses.
REQ-017 frame_start  output  1  one-cycle pulse, aligned with the colour outputs, at pixel (0,0).
REQ-018 frame_count  output  16  number of completed frames since reset.

Function
REQ-019 Frame geometry: H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_total = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 hcount increments every cycle and wraps from H_total-1 to 0.
REQ-021 vcount increments only on the hcount wrap and wraps from V_total-1 to 0 on the same edge as the hcount wrap.
REQ-022 Raw hsync is low while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
REQ-023 Raw vsync is low while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491; it is line-granular and changes together with hcount going to 0.
REQ-024 Raw active is 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-025 Raw hsync, raw vsync, raw active and raw frame_start (hcount==0 and vcount==0) pass through a PIPE_DELAY-stage shift register before reaching the outputs.
REQ-026 The colour outputs are registered once from data.
REQ-027 Alignment: data sampled at edge k belongs to the counter values presented PIPE_DELAY-1 cycles earlier; the colour and sync outputs for a pixel appear on the same cycle.
REQ-028 Each colour bit equals the corresponding data bit ANDed with the delayed active flag; the bit mapping is red_out=data[0], green_out=data[1], blue_out=data[2].
REQ-029 frame_count increments by 1 on the cycle the delayed frame_start is asserted, except for the first frame_start after reset, and wraps from 0xFFFF to 0.
REQ-030 The first frame after reset does not count; frame_count=1 when the second frame begins.
REQ-031 hcount, vcount and frame_count are unsigned with no saturation; out-of-range counter values cannot occur.
REQ-032 The data input is ignored while the delayed active flag is 0.

Reset
REQ-033 While reset=0: hcount=0, vcount=0, hsync=1, vsync=1, colour outputs=0, frame_start=0, frame_count=0.
REQ-034 While reset=0, every delay-line stage holds inactive values (sync=1, active=0, frame_start=0).
REQ-035 Reset asserted mid-line or mid-frame takes effect immediately, with no partial sync pulse continuing.
REQ-036 After reset release, the first edge moves hcount from 0 to 1.
REQ-037 After reset release, the raw frame_start for (0,0) is generated; the delayed frame_start pulse therefore appears PIPE_DELAY cycles after release.

Verification
REQ-038 Release reset, run 2 frames -> hsync low for exactly 96 cycles per 800-cycle line; vsync low for exactly 1600 cycles (2 lines) per 420000-cycle frame.
REQ-039 Drive data=3'b111 constantly -> red_out/green_out/blue_out are 1 for exactly 640x480 pixels per frame and 0 during every hsync and vsync pulse.
REQ-040 Drive data = hcount[2:0] with one upstream register (PIPE_DELAY=2) -> at each output cycle the colour equals the hcount sampled 2 cycles earlier, for every visible pixel.
REQ-041 frame_start check: frame_start pulses once per 420000 cycles; frame_count reads 0, 1, 2 on the first three pulses.
REQ-042 Assert reset at hcount=700 (inside the hsync pulse) -> hsync goes to 1 and hcount to 0 asynchronously, without waiting for a clock edge.
REQ-043 Force frame_count to 0xFFFF, reach the next frame start -> frame_count=0x0000.
